// File: rtl/nic8_pkg.sv
//==============================================================================
// Module   : nic8_pkg
// Purpose  : Shared phase encodings and instruction-register field layout for nic8.
// Revision : 1.0
//==============================================================================
`default_nettype none

package nic8_pkg;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_FETCH = 2'd1,
      PH_EXEC  = 2'd2,
      PH_DONE  = 2'd3
   } phase_e;

   localparam int IR_BIT7    = 7;
   localparam int IR_BIT6    = 6;
   localparam int IR_SRC_MSB = 5;
   localparam int IR_SRC_LSB = 3;
   localparam int IR_DST_MSB = 2;
   localparam int IR_DST_LSB = 0;

   // Source code 0 means the operand is the ROM byte following the opcode
   localparam logic [2:0] SRC_ROM = 3'd0;

   function automatic logic [2:0] ir_source(input logic [7:0] ir_val);
      return ir_val[IR_SRC_MSB:IR_SRC_LSB];
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
//==============================================================================
// Module   : pc_reg
// Purpose  : 8-bit program counter with async clear; load beats increment beats hold.
// Revision : 1.0
//==============================================================================
`default_nettype none

module pc_reg (
   input  logic       clk,
   input  logic       resetBar,
   input  logic       load,
   input  logic       inc,
   input  logic [7:0] load_val,
   output logic [7:0] pc
);

   logic [7:0] pc_d;
   logic [7:0] pc_q;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_val;
      end else if (inc) begin
         pc_d = pc_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         pc_q <= 8'h00;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
//==============================================================================
// Module   : cpu_sequencer
// Purpose  : Two-phase fetch/execute sequencer with free-run and single-step control.
// Revision : 1.0
//==============================================================================
`default_nettype none

module cpu_sequencer
   import nic8_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               resetBar,
   input  logic               run,
   input  logic               stepReq,
   output logic               stepAck,
   input  logic [7:0]         romData,
   input  logic               doJump,
   input  logic [7:0]         dbus,
   output logic [7:0]         pc,
   output logic [7:0]         ir,
   output logic [1:0]         phase,
   output logic               halted,
   output logic [COUNT_W-1:0] retired
);

   localparam logic [COUNT_W-1:0] RETIRE_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   phase_e             phase_q,    phase_d;
   logic               stepping_q, stepping_d;
   logic               step_ack_q, step_ack_d;
   logic               halted_q,   halted_d;
   logic [7:0]         ir_q,       ir_d;
   logic [7:0]         fetch_pc_q, fetch_pc_d;
   logic [COUNT_W-1:0] retired_q,  retired_d;

   logic pc_load;
   logic pc_inc;
   logic halt_now;

   pc_reg u_pc_reg (
      .clk      (clk),
      .resetBar (resetBar),
      .load     (pc_load),
      .inc      (pc_inc),
      .load_val (dbus),
      .pc       (pc)
   );

   // Jump-to-self: target equals the address the current instruction came from
   assign halt_now = doJump && (dbus == fetch_pc_q);

   always_comb begin
      phase_d    = phase_q;
      stepping_d = stepping_q;
      step_ack_d = step_ack_q;
      halted_d   = halted_q;
      ir_d       = ir_q;
      fetch_pc_d = fetch_pc_q;
      retired_d  = retired_q;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;

      case (phase_q)
         PH_IDLE: begin
            if (!halted_q) begin
               if (run) begin
                  phase_d = PH_FETCH;
               end else if (stepReq) begin
                  phase_d    = PH_FETCH;
                  stepping_d = 1'b1;
               end
            end
         end

         PH_FETCH: begin
            ir_d       = romData;
            fetch_pc_d = pc;
            pc_inc     = 1'b1;
            phase_d    = PH_EXEC;
         end

         PH_EXEC: begin
            if (doJump) begin
               pc_load = 1'b1;
            end else if (ir_source(ir_q) == SRC_ROM) begin
               pc_inc = 1'b1;
            end
            retired_d = retired_q + RETIRE_ONE;
            if (halt_now) begin
               halted_d = 1'b1;
            end
            // A halting step still hands back its acknowledge before settling in IDLE
            if (stepping_q) begin
               phase_d    = PH_DONE;
               step_ack_d = 1'b1;
            end else if (run && !halt_now) begin
               phase_d = PH_FETCH;
            end else begin
               phase_d = PH_IDLE;
            end
         end

         PH_DONE: begin
            if (!stepReq) begin
               step_ack_d = 1'b0;
               stepping_d = 1'b0;
               phase_d    = PH_IDLE;
            end
         end

         default: begin
            phase_d = PH_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         phase_q    <= PH_IDLE;
         stepping_q <= 1'b0;
         step_ack_q <= 1'b0;
         halted_q   <= 1'b0;
         ir_q       <= 8'h00;
         fetch_pc_q <= 8'h00;
         retired_q  <= '0;
      end else begin
         phase_q    <= phase_d;
         stepping_q <= stepping_d;
         step_ack_q <= step_ack_d;
         halted_q   <= halted_d;
         ir_q       <= ir_d;
         fetch_pc_q <= fetch_pc_d;
         retired_q  <= retired_d;
      end
   end

   assign phase   = phase_q;
   assign stepAck = step_ack_q;
   assign halted  = halted_q;
   assign ir      = ir_q;
   assign retired = retired_q;

endmodule

`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Two-phase fetch/execute sequencer for the nic8 core. It owns the program counter and instruction register and drives the ROM address. It advances the machine one instruction at a time, either free-running or under a four-phase single-step handshake from the debug front panel. The combinational control decoder reads `ir` from this block and returns `doJump`. The sequencer applies jumps, consumes ROM immediates, and detects the jump-to-self halt idiom.

## Interface
Parameters:
- `COUNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` input, 1 bit: system clock. All state changes on the rising edge.
- `resetBar` input, 1 bit: asynchronous, active-low reset.
- `run` input, 1 bit: free-run enable, level sensitive.
- `stepReq` input, 1 bit: single-step request, four-phase handshake.
- `stepAck` output, 1 bit: single-step acknowledge.
- `romData` input, 8 bits: ROM byte at address `pc`.
- `doJump` input, 1 bit: jump decision from the control decoder. Only valid in the EXEC phase.
- `dbus` input, 8 bits: data bus value. It is the jump target when `doJump` is high.
- `pc` output, 8 bits: program counter and ROM address.
- `ir` output, 8 bits: current instruction. Bits are {bit7, bit6, source[2:0], dest[2:0]}.
- `phase` output, 2 bits: IDLE=0, FETCH=1, EXEC=2, DONE=3.
- `halted` output, 1 bit: set when a jump-to-self instruction executes.
- `retired` output, `COUNT_W` bits: count of executed instructions. Wraps.

## Operation
- Reset (async, `resetBar` low):
  - `phase`=IDLE, `pc`=0x00, `ir`=0x00.
  - `stepAck`=0, `halted`=0, `retired`=0, internal `stepping`=0, `fetchPc`=0x00.
- IDLE:
  - If `run`=1, go to FETCH.
  - Else if `stepReq`=1, go to FETCH and set `stepping`=1.
  - If both are high, `run` wins and `stepping` stays 0. A pending `stepReq` is serviced after `run` drops.
- FETCH:
  - `ir` <= `romData`, `fetchPc` <= `pc`, `pc` <= `pc`+1 (8-bit wrap, 0xFF becomes 0x00).
  - Go to EXEC.
- EXEC, where `source` = `ir[5:3]`:
  - `pc` update: if `doJump`=1, `pc` <= `dbus`. Else if `source`==0 (ROM immediate), `pc` <= `pc`+1, wrapping. Else `pc` holds.
  - `doJump` takes priority over the immediate increment.
  - `retired` <= `retired`+1.
  - Halt: if `doJump`=1 and `dbus`==`fetchPc`, then `halted` <= 1 and go to IDLE. The halt is sticky until reset. While `halted`=1, IDLE ignores `run` and `stepReq`, except that a pending step is still acknowledged (see below).
  - Otherwise, if `stepping`=1, go to DONE. Else if `run`=1, go to FETCH. Else go to IDLE.
  - A step that ends in halt still goes to DONE and acknowledges before the halt takes effect in IDLE.
- DONE:
  - `stepAck`=1.
  - When `stepReq`=0, clear `stepAck` and `stepping`, and go to IDLE.
  - `run` is ignored in DONE.
- Dropping `run` mid-instruction never aborts the instruction. EXEC always completes.
- Asserting reset during any phase aborts the instruction and restores the reset values immediately, without waiting for a clock edge.

## Timing
- Every instruction takes exactly 2 cycles (FETCH, then EXEC). Free-run throughput is 1 instruction per 2 cycles, with no idle cycle between instructions.
- `romData` must be valid for the `pc` value presented during FETCH and during an EXEC with `source`==0. The ROM is asynchronous/combinational.
- `ir` changes only at the FETCH-to-EXEC edge. The decoder outputs are stable for the whole EXEC cycle.
- Step latency:
  - `stepReq` rise seen in IDLE at edge N gives FETCH at N, EXEC at N+1, and `stepAck`=1 from N+2.
  - `stepAck` falls on the first edge where `stepReq`=0 is sampled.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package `nic8_pkg`:
  - phase encodings IDLE/FETCH/EXEC/DONE;
  - IR field positions (bit7, bit6, source, dest);
  - `SRC_ROM`=0.
- Sub-module `pc_reg`: an 8-bit register with async active-low clear and priority load > increment > hold. The sequencer instantiates it for `pc`.
- The rest is a single FSM plus the `ir`, `fetchPc` and `retired` registers.

## Test plan
- Reset, then `run`=1 with ROM[0]=0x12 (source 2), `doJump`=0: phase goes 1,2,1,2; `pc` goes 0x01 then 0x02; `retired`=2 after 4 cycles.
- ROM immediate: ROM[0]=0x02 (source 0), ROM[1]=0x55 → after EXEC, `pc`=0x02 and `ir`=0x02.
- Jump: at address 0x10, `doJump`=1, `dbus`=0x40 → next FETCH presents `pc`=0x40. Also fetch at `pc`=0xFF → `pc` wraps to 0x00.
- Halt: the instruction at 0x07 executes with `doJump`=1 and `dbus`=0x07 → `halted`=1, phase IDLE, and `pc` stays 0x07 while `run` remains high.
- Single step with `run`=0:
  - `stepReq` rises → `stepAck` rises exactly 2 cycles later and `retired` increments by 1.
  - Holding `stepReq` high causes no second instruction.
  - `stepAck` falls one cycle after `stepReq` falls.
  - Raising `run` and `stepReq` together → free-run occurs with no `stepAck`.
- Pull `resetBar` low mid-EXEC while `stepAck` is pending → all outputs go to reset values before the next clock edge. Release, and the first FETCH is from `pc`=0x00.
